inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
- Write-side counterpart of the instruction decoder.
- Accepts decoded instruction fields over a valid/ready handshake: cond, opcd, dest, source, source2.
- Packs each set of fields into the 16-bit instruction format and writes the word sequentially into instruction memory from a programmed base address.
- Can read back each written word and compare it against the word that was written.
- Used to load programs into instruction memory before the processor runs.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of memory words; must equal 2**ADDR_W.
- VERIFY, 1, enables read-back verification of each word when 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- base_addr  in  ADDR_W  first memory address written; sampled on start.
- count  in  ADDR_W+1  number of instructions to load; sampled on start.
- in_valid  in  1  instruction fields on the field inputs are valid.
- in_ready  out  1  loader accepts the fields this cycle.
- cond  in  2  condition field.
- opcd  in  4  opcode field.
- dest  in  3  destination register.
- source  in  3  source register.
- source2  in  4  second source / shift field.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  16  packed instruction word.
- mem_rdata  in  16  memory read data, valid the cycle after mem_re.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at end of load.
- err  out  1  sticky verify mismatch flag.
- err_addr  out  ADDR_W  address of the first mismatch.
- words_written  out  ADDR_W+1  count of words written in the current load.

Behaviour:

Packing:
- mem_wdata = {cond, opcd, dest, source, source2}, i.e. bits [15:14], [13:10], [9:7], [6:4], [3:0].
- The packed word is captured into a hold register on handshake.
- mem_wdata always drives the hold register.

Reset (rst_n low, asynchronous):
- State is IDLE.
- All outputs are 0: in_ready, mem_we, mem_re, mem_addr, mem_wdata, busy, done, err, err_addr, words_written.
- Reset mid-load abandons the load immediately; no further memory strobes are issued after release.

Outputs and handshake:
- Moore outputs decoded from state; mem_addr = address register.
- in_ready depends on state only, never on in_valid.
- Transfer occurs when in_valid && in_ready.

States:
- IDLE: busy=0.
  - start with count!=0: load addr=base_addr, remaining=count; clear words_written, err, err_addr; go to ACCEPT.
  - start with count==0: done pulses for one cycle; stay IDLE; err and words_written cleared.
- ACCEPT: busy=1, in_ready=1. On transfer, capture the packed word and go to WRITE. Otherwise wait indefinitely.
- WRITE: mem_we=1 for exactly one cycle at addr. Next state is READ if VERIFY=1, otherwise ADVANCE.
- READ: mem_re=1 for one cycle at the same addr; go to CHECK.
- CHECK: compare mem_rdata to the hold register.
  - On mismatch: set err; if err was previously 0, err_addr=addr.
  - Always go to ADVANCE; the load never aborts on error.
- ADVANCE:
  - words_written+1, remaining-1.
  - addr+1, wrapping DEPTH-1 -> 0.
  - If remaining becomes 0, go to DONE; otherwise go to ACCEPT.
- DONE: done=1 for one cycle, busy=1; go to IDLE.

Timing and boundary cases:
- Cycles per word excluding handshake wait: 3 with VERIFY=0 (ACCEPT, WRITE, ADVANCE); 5 with VERIFY=1.
- start while busy: ignored.
- in_valid outside ACCEPT: ignored; no transfer.
- count=DEPTH: every address written exactly once; addr ends at base_addr.
- words_written, err and err_addr hold their values in IDLE until the next start.
- mem_we and mem_re are never asserted in the same cycle.

Test Plan:
- Basic pack, VERIFY=1, echo memory: start, base_addr=0x10, count=1; fields cond=2'b10, opcd=4'hA, dest=3'd5, source=3'd3, source2=4'h7 -> one mem_we at addr 0x10 with mem_wdata=0xAAB7; mem_re at 0x10; done pulse; err=0; words_written=1.
- Wrap-around: base_addr=0xFE, count=3 -> writes at 0xFE, 0xFF, 0x00 in order; words_written=3.
- Backpressure: in_valid low for 10 cycles in ACCEPT -> no mem_we; in_ready stays 1; load resumes when in_valid rises.
- Verify mismatch: memory model corrupts bit 0 at addr 0x21 during a 4-word load from 0x20 -> err=1, err_addr=0x21; remaining words still written; done pulses.
- count=0 start -> done pulse next cycle; no mem_we or mem_re; busy stays 0. start pulsed while busy -> ignored.
- Reset mid-load: rst_n low during WRITE -> mem_we=0 immediately and all outputs 0; after release, state is IDLE and no strobes occur until a new start.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: packs decoded instruction fields into 16-bit words and writes them
// sequentially into instruction memory, optionally reading each word back to verify it.
module inst_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int VERIFY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        cond,
  input  logic [3:0]        opcd,
  input  logic [2:0]        dest,
  input  logic [2:0]        source,
  input  logic [3:0]        source2,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   words_written
);
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_READ, S_CHECK, S_ADVANCE, S_DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_err_addr;
  logic [ADDR_W:0]   r_rem, r_words;
  logic [15:0]       r_hold;
  logic              r_err, r_zdone;
  logic              w_xfer, w_start_load, w_start_zero;
  assign w_xfer       = in_valid && in_ready;
  assign w_start_load = r_state == S_IDLE && start && count != '0;
  assign w_start_zero = r_state == S_IDLE && start && count == '0;
  assign in_ready      = r_state == S_ACCEPT;
  assign mem_we        = r_state == S_WRITE;
  assign mem_re        = r_state == S_READ;
  assign busy          = r_state != S_IDLE;
  // a zero-length load never leaves IDLE, so its done pulse comes from a flag
  assign done          = r_state == S_DONE || r_zdone;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_hold;
  assign err           = r_err;
  assign err_addr      = r_err_addr;
  assign words_written = r_words;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = w_start_load ? S_ACCEPT : S_IDLE;
      S_ACCEPT:  w_next = w_xfer ? S_WRITE : S_ACCEPT;
      S_WRITE:   w_next = VERIFY != 0 ? S_READ : S_ADVANCE;
      S_READ:    w_next = S_CHECK;
      S_CHECK:   w_next = S_ADVANCE;
      S_ADVANCE: w_next = r_rem == 1 ? S_DONE : S_ACCEPT;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_hold     <= '0;
      r_words    <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_zdone    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_zdone <= w_start_zero;
      if (w_start_load) begin
        r_addr     <= base_addr;
        r_rem      <= count;
        r_words    <= '0;
        r_err      <= 1'b0;
        r_err_addr <= '0;
      end
      if (w_start_zero) begin
        r_words <= '0;
        r_err   <= 1'b0;
      end
      if (r_state == S_ACCEPT && w_xfer)
        r_hold <= {cond, opcd, dest, source, source2};
      if (r_state == S_CHECK && mem_rdata != r_hold) begin
        r_err <= 1'b1;
        if (!r_err) r_err_addr <= r_addr;
      end
      if (r_state == S_ADVANCE) begin
        r_words <= r_words + 1'b1;
        r_rem   <= r_rem - 1'b1;
        r_addr  <= r_addr == ADDR_W'(DEPTH - 1) ? '0 : r_addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb_inst_encoder_loader: directed bench with an expected-write scoreboard against an
// echo memory that can corrupt one address on read-back.
module tb_inst_encoder_loader;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [7:0]  base_addr = 0;
  logic [8:0]  count = 0;
  logic [1:0]  cond = 0;
  logic [3:0]  opcd = 0, source2 = 0;
  logic [2:0]  dest = 0, source = 0;
  logic        in_ready, mem_we, mem_re, busy, done, err;
  logic [7:0]  mem_addr, err_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [8:0]  words_written;

  inst_encoder_loader #(.ADDR_W(8), .DEPTH(256), .VERIFY(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .cond(cond), .opcd(opcd), .dest(dest),
    .source(source), .source2(source2), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .err(err), .err_addr(err_addr), .words_written(words_written)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  int          corrupt_addr = -1;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr] ^ ((int'(mem_addr) == corrupt_addr) ? 16'h0001 : 16'h0000);
  end

  logic [23:0] exp_q[$], obs_q[$];
  int we_cnt = 0, re_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      obs_q.push_back({mem_addr, mem_wdata});
      we_cnt++;
    end
    if (mem_re) re_cnt++;
    if (done) done_cnt++;
    if (mem_we && mem_re) overlap_cnt++;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack(input logic [1:0] c, input logic [3:0] o,
                                       input logic [2:0] d, input logic [2:0] s, input logic [3:0] s2);
    return {c, o, d, s, s2};
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({in_ready, mem_we, mem_re, mem_addr, mem_wdata, busy, done, err, err_addr, words_written});
  endfunction

  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    @(negedge clk);
    start = 1; base_addr = b; count = n;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [7:0] a, input logic [15:0] w);
    int n = 0;
    {cond, opcd, dest, source, source2} = w;
    in_valid = 1;
    exp_q.push_back({a, w});
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic send_rand(input logic [7:0] a);
    send(a, 16'($urandom));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      if (obs_q.size() == 0) begin
        check({tag, "_missing_write"}, 64'(exp_q.pop_front()), 64'hFFFF_FFFF);
      end else begin
        check({tag, "_write"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
      end
    end
    check({tag, "_extra_writes"}, 64'(obs_q.size()), 0);
  endtask

  initial begin
    int we0, re0, d0;
    logic [7:0] ab;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_outputs", all_outs(), 0);

    // basic pack with verify
    re0 = re_cnt; d0 = done_cnt;
    do_start(8'h10, 9'd1);
    check("basic_busy", 64'(busy), 1);
    check("basic_pack_const", 64'(pack(2'b10, 4'hA, 3'd5, 3'd3, 4'h7)), 64'hAAB7);
    send(8'h10, 16'hAAB7);
    wait_done();
    drain("basic");
    check("basic_reads", 64'(re_cnt - re0), 1);
    check("basic_done", 64'(done_cnt - d0), 1);
    check("basic_err", 64'(err), 0);
    check("basic_words", 64'(words_written), 1);
    check("basic_idle_busy", 64'(busy), 0);

    // wrap-around at the top of memory
    do_start(8'hFE, 9'd3);
    send_rand(8'hFE);
    send_rand(8'hFF);
    send_rand(8'h00);
    wait_done();
    drain("wrap");
    check("wrap_words", 64'(words_written), 3);

    // backpressure: ready holds and nothing is written while valid stays low
    we0 = we_cnt;
    do_start(8'h30, 9'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_ready", 64'(in_ready), 1);
      @(negedge clk);
    end
    check("bp_no_write", 64'(we_cnt - we0), 0);
    send(8'h30, pack(2'b01, 4'h3, 3'd7, 3'd0, 4'hF));
    wait_done();
    drain("bp");

    // verify mismatch at 0x21; a start while busy must be ignored
    corrupt_addr = 'h21;
    d0 = done_cnt;
    do_start(8'h20, 9'd4);
    send_rand(8'h20);
    @(negedge clk);
    start = 1; base_addr = 8'h80; count = 9'd0;
    @(negedge clk);
    start = 0;
    send_rand(8'h21);
    send_rand(8'h22);
    send_rand(8'h23);
    wait_done();
    drain("verify");
    check("verify_err", 64'(err), 1);
    check("verify_err_addr", 64'(err_addr), 64'h21);
    check("verify_words", 64'(words_written), 4);
    check("verify_done_once", 64'(done_cnt - d0), 1);
    corrupt_addr = -1;
    @(negedge clk);
    check("hold_err_idle", 64'(err), 1);

    // zero-length load
    we0 = we_cnt; re0 = re_cnt;
    do_start(8'h55, 9'd0);
    check("zero_done", 64'(done), 1);
    check("zero_busy", 64'(busy), 0);
    check("zero_err_cleared", 64'(err), 0);
    check("zero_words_cleared", 64'(words_written), 0);
    @(negedge clk);
    check("zero_done_single", 64'(done), 0);
    check("zero_no_strobes", 64'((we_cnt - we0) + (re_cnt - re0)), 0);

    // reset during WRITE
    ab = 8'h40;
    do_start(ab, 9'd2);
    {cond, opcd, dest, source, source2} = 16'h1234;
    in_valid = 1;
    for (int i = 0; i < 20 && !mem_we; i++) @(negedge clk);
    in_valid = 0;
    check("rst_in_write", 64'(mem_we), 1);
    rst_n = 0;
    #1;
    check("rst_async_outputs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1;
    exp_q.delete();
    @(negedge clk);
    obs_q.delete();
    we0 = we_cnt; re0 = re_cnt;
    repeat (10) @(negedge clk);
    check("rst_no_strobes", 64'((we_cnt - we0) + (re_cnt - re0)), 0);
    check("rst_idle_outputs", all_outs(), 0);
    check("never_we_and_re", 64'(overlap_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
